// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The stage drives the request side; the memory answers with a one-cycle ack.
`timescale 1ns/1ps
interface mem_stage_ctrl_if;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic        DMEM_ACK;
  logic [31:0] DMEM_RDATA;

  modport master (
    output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
    input  DMEM_ACK, DMEM_RDATA
  );

  modport slave (
    input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
    output DMEM_ACK, DMEM_RDATA
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: word load/store over a req/ack bus with stall and timeout,
// branch resolution, and the MEM/WB output register. State changes on negedge CLK.
`timescale 1ns/1ps
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16  // legal range 1..255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  input  logic [31:0] IN_PC,
  input  logic [5:0]  IN_RD,
  input  logic        IN_Branch,
  input  logic        IN_ZERO,
  input  logic        IN_MemRead,
  input  logic        IN_MemWrite,
  input  logic        IN_RegWrite,
  input  logic        IN_MemToReg,
  input  logic [31:0] IN_EXE_RESULT,
  input  logic [31:0] IN_READ_DATA_2,
  mem_stage_ctrl_if.master dmem,
  output logic        STALL,
  output logic        PC_SRC,
  output logic [31:0] BRANCH_PC,
  output logic        OUT_VALID,
  output logic        OUT_RegWrite,
  output logic        OUT_MemToReg,
  output logic [5:0]  OUT_RD,
  output logic [31:0] OUT_MEM_DATA,
  output logic [31:0] OUT_ALU_RESULT,
  output logic        ERR_MISALIGN,
  output logic        ERR_TIMEOUT
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  // Instruction fields captured at launch so upstream hold is not relied upon
  logic [5:0]  rd_p0, rd_p0_d;
  logic        regwr_p0, regwr_p0_d;
  logic        m2r_p0, m2r_p0_d;
  logic        load_p0, load_p0_d;

  logic        vld_p1_d, regwr_p1_d, m2r_p1_d;
  logic [5:0]  rd_p1_d;
  logic [31:0] mem_data_p1_d, alu_p1_d;
  logic        err_mis_d, err_to_d;

  logic        mem_op, misaligned, expired;

  assign mem_op     = IN_VALID & (IN_MemRead | IN_MemWrite);
  assign misaligned = |IN_EXE_RESULT[1:0];
  assign expired    = ({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM;

  assign STALL     = ((state_q == S_IDLE) & mem_op & ~misaligned) |
                     ((state_q == S_WAIT) & ~dmem.DMEM_ACK);
  assign PC_SRC    = IN_VALID & IN_Branch & IN_ZERO & (state_q != S_WAIT);
  assign BRANCH_PC = IN_PC;

  assign dmem.DMEM_REQ   = req_q;
  assign dmem.DMEM_WE    = we_q;
  assign dmem.DMEM_ADDR  = addr_q;
  assign dmem.DMEM_WDATA = wdata_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_p0_d       = rd_p0;
    regwr_p0_d    = regwr_p0;
    m2r_p0_d      = m2r_p0;
    load_p0_d     = load_p0;
    vld_p1_d      = OUT_VALID;
    regwr_p1_d    = OUT_RegWrite;
    m2r_p1_d      = OUT_MemToReg;
    rd_p1_d       = OUT_RD;
    mem_data_p1_d = OUT_MEM_DATA;
    alu_p1_d      = OUT_ALU_RESULT;
    err_mis_d     = 1'b0;
    err_to_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!mem_op) begin
          vld_p1_d   = IN_VALID;
          regwr_p1_d = IN_VALID & IN_RegWrite;
          m2r_p1_d   = IN_MemToReg;
          rd_p1_d    = IN_RD;
          alu_p1_d   = IN_EXE_RESULT;
        end else if (misaligned) begin
          vld_p1_d   = 1'b1;
          regwr_p1_d = 1'b0;
          m2r_p1_d   = IN_MemToReg;
          rd_p1_d    = IN_RD;
          alu_p1_d   = IN_EXE_RESULT;
          err_mis_d  = 1'b1;
        end else begin
          // Both MemRead and MemWrite set resolves to a write
          req_d      = 1'b1;
          we_d       = IN_MemWrite;
          addr_d     = IN_EXE_RESULT;
          wdata_d    = IN_READ_DATA_2;
          cnt_d      = 8'd0;
          rd_p0_d    = IN_RD;
          regwr_p0_d = IN_RegWrite;
          m2r_p0_d   = IN_MemToReg;
          load_p0_d  = ~IN_MemWrite;
          vld_p1_d   = 1'b0;
          regwr_p1_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem.DMEM_ACK) begin
          req_d      = 1'b0;
          vld_p1_d   = 1'b1;
          regwr_p1_d = regwr_p0;
          m2r_p1_d   = m2r_p0;
          rd_p1_d    = rd_p0;
          alu_p1_d   = addr_q;
          if (load_p0) mem_data_p1_d = dmem.DMEM_RDATA;
          state_d    = S_IDLE;
        end else begin
          cnt_d = sat_inc8(cnt_q);
          if (expired) begin
            req_d      = 1'b0;
            err_to_d   = 1'b1;
            vld_p1_d   = 1'b1;
            regwr_p1_d = 1'b0;
            m2r_p1_d   = m2r_p0;
            rd_p1_d    = rd_p0;
            alu_p1_d   = addr_q;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MEM/WB register boundary
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      rd_p0          <= 6'd0;
      regwr_p0       <= 1'b0;
      m2r_p0         <= 1'b0;
      load_p0        <= 1'b0;
      OUT_VALID      <= 1'b0;
      OUT_RegWrite   <= 1'b0;
      OUT_MemToReg   <= 1'b0;
      OUT_RD         <= 6'd0;
      OUT_MEM_DATA   <= 32'd0;
      OUT_ALU_RESULT <= 32'd0;
      ERR_MISALIGN   <= 1'b0;
      ERR_TIMEOUT    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_p0          <= rd_p0_d;
      regwr_p0       <= regwr_p0_d;
      m2r_p0         <= m2r_p0_d;
      load_p0        <= load_p0_d;
      OUT_VALID      <= vld_p1_d;
      OUT_RegWrite   <= regwr_p1_d;
      OUT_MemToReg   <= m2r_p1_d;
      OUT_RD         <= rd_p1_d;
      OUT_MEM_DATA   <= mem_data_p1_d;
      OUT_ALU_RESULT <= alu_p1_d;
      ERR_MISALIGN   <= err_mis_d;
      ERR_TIMEOUT    <= err_to_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus random instructions
// compared against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;
  localparam int TMO = 4;

  logic        CLK = 1'b1;
  logic        RST_N;
  logic        IN_VALID, IN_Branch, IN_ZERO, IN_MemRead, IN_MemWrite, IN_RegWrite, IN_MemToReg;
  logic [31:0] IN_PC, IN_EXE_RESULT, IN_READ_DATA_2;
  logic [5:0]  IN_RD;
  logic        STALL, PC_SRC, OUT_VALID, OUT_RegWrite, OUT_MemToReg, ERR_MISALIGN, ERR_TIMEOUT;
  logic [31:0] BRANCH_PC, OUT_MEM_DATA, OUT_ALU_RESULT;
  logic [5:0]  OUT_RD;

  mem_stage_ctrl_if dmem_bus ();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_PC(IN_PC), .IN_RD(IN_RD),
    .IN_Branch(IN_Branch), .IN_ZERO(IN_ZERO),
    .IN_MemRead(IN_MemRead), .IN_MemWrite(IN_MemWrite),
    .IN_RegWrite(IN_RegWrite), .IN_MemToReg(IN_MemToReg),
    .IN_EXE_RESULT(IN_EXE_RESULT), .IN_READ_DATA_2(IN_READ_DATA_2),
    .dmem(dmem_bus.master),
    .STALL(STALL), .PC_SRC(PC_SRC), .BRANCH_PC(BRANCH_PC),
    .OUT_VALID(OUT_VALID), .OUT_RegWrite(OUT_RegWrite), .OUT_MemToReg(OUT_MemToReg),
    .OUT_RD(OUT_RD), .OUT_MEM_DATA(OUT_MEM_DATA), .OUT_ALU_RESULT(OUT_ALU_RESULT),
    .ERR_MISALIGN(ERR_MISALIGN), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_mem_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req"}, 32'(dmem_bus.DMEM_REQ), 32'd0);
    check_val({tag, "_we"}, 32'(dmem_bus.DMEM_WE), 32'd0);
    check_val({tag, "_addr"}, dmem_bus.DMEM_ADDR, 32'd0);
    check_val({tag, "_wdata"}, dmem_bus.DMEM_WDATA, 32'd0);
    check_val({tag, "_vld"}, 32'(OUT_VALID), 32'd0);
    check_val({tag, "_rw"}, 32'(OUT_RegWrite), 32'd0);
    check_val({tag, "_m2r"}, 32'(OUT_MemToReg), 32'd0);
    check_val({tag, "_rd"}, 32'(OUT_RD), 32'd0);
    check_val({tag, "_mdata"}, OUT_MEM_DATA, 32'd0);
    check_val({tag, "_alu"}, OUT_ALU_RESULT, 32'd0);
    check_val({tag, "_emis"}, 32'(ERR_MISALIGN), 32'd0);
    check_val({tag, "_etmo"}, 32'(ERR_TIMEOUT), 32'd0);
  endtask

  // Presents one instruction (called just after a negedge) and follows it to completion.
  // ack_at: WAIT cycle (1-based) carrying the ack; > TMO means none. For non-memory
  // instructions ack_at==0 pulses a stray ack that must be ignored.
  task automatic do_instr(input logic v, input logic [5:0] rd, input logic br, input logic zr,
                          input logic mr, input logic mw, input logic rw, input logic m2r,
                          input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rdata);
    logic mem_op, mis, is_load;
    mem_op  = v & (mr | mw);
    mis     = addr[1:0] != 2'b00;
    is_load = mr & ~mw;
    IN_VALID = v; IN_RD = rd; IN_Branch = br; IN_ZERO = zr; IN_MemRead = mr;
    IN_MemWrite = mw; IN_RegWrite = rw; IN_MemToReg = m2r; IN_PC = pc;
    IN_EXE_RESULT = addr; IN_READ_DATA_2 = wd;
    dmem_bus.DMEM_ACK = (!mem_op && ack_at == 0);
    dmem_bus.DMEM_RDATA = rdata;
    #1;
    check_val("stall_idle", 32'(STALL), 32'(mem_op & ~mis));
    check_val("pc_src", 32'(PC_SRC), 32'(v & br & zr));
    check_val("branch_pc", BRANCH_PC, pc);
    @(negedge CLK); #1;
    dmem_bus.DMEM_ACK = 1'b0;
    if (!mem_op || mis) begin
      check_val("req_idle", 32'(dmem_bus.DMEM_REQ), 32'd0);
      check_val("emis", 32'(ERR_MISALIGN), 32'(mem_op & mis));
      check_val("etmo_idle", 32'(ERR_TIMEOUT), 32'd0);
      check_val("out_vld", 32'(OUT_VALID), mem_op ? 32'd1 : 32'(v));
      check_val("out_rw", 32'(OUT_RegWrite), mem_op ? 32'd0 : 32'(v & rw));
      check_val("mdata_hold", OUT_MEM_DATA, exp_mem_data);
      if (!mem_op) begin
        check_val("out_rd", 32'(OUT_RD), 32'(rd));
        check_val("out_alu", OUT_ALU_RESULT, addr);
        check_val("out_m2r", 32'(OUT_MemToReg), 32'(m2r));
      end
      return;
    end
    check_val("req_launch", 32'(dmem_bus.DMEM_REQ), 32'd1);
    check_val("we_launch", 32'(dmem_bus.DMEM_WE), 32'(mw));
    check_val("addr_launch", dmem_bus.DMEM_ADDR, addr);
    check_val("wdata_launch", dmem_bus.DMEM_WDATA, wd);
    check_val("bubble_vld", 32'(OUT_VALID), 32'd0);
    check_val("bubble_rw", 32'(OUT_RegWrite), 32'd0);
    for (int k = 1; k <= TMO; k++) begin
      dmem_bus.DMEM_ACK = (k == ack_at);
      dmem_bus.DMEM_RDATA = rdata;
      #1;
      check_val("stall_wait", 32'(STALL), 32'(k != ack_at));
      check_val("pc_src_wait", 32'(PC_SRC), 32'd0);
      check_val("addr_wait", dmem_bus.DMEM_ADDR, addr);
      @(negedge CLK); #1;
      if (k == ack_at) begin
        dmem_bus.DMEM_ACK = 1'b0;
        if (is_load) exp_mem_data = rdata;
        check_val("req_done", 32'(dmem_bus.DMEM_REQ), 32'd0);
        check_val("done_vld", 32'(OUT_VALID), 32'd1);
        check_val("done_rw", 32'(OUT_RegWrite), 32'(rw));
        check_val("done_rd", 32'(OUT_RD), 32'(rd));
        check_val("done_m2r", 32'(OUT_MemToReg), 32'(m2r));
        check_val("done_alu", OUT_ALU_RESULT, addr);
        check_val("done_mdata", OUT_MEM_DATA, exp_mem_data);
        check_val("done_etmo", 32'(ERR_TIMEOUT), 32'd0);
        return;
      end
      if (k == TMO) begin
        check_val("req_tmo", 32'(dmem_bus.DMEM_REQ), 32'd0);
        check_val("etmo", 32'(ERR_TIMEOUT), 32'd1);
        check_val("tmo_vld", 32'(OUT_VALID), 32'd1);
        check_val("tmo_rw", 32'(OUT_RegWrite), 32'd0);
        check_val("tmo_mdata", OUT_MEM_DATA, exp_mem_data);
      end else begin
        check_val("req_held", 32'(dmem_bus.DMEM_REQ), 32'd1);
        check_val("we_held", 32'(dmem_bus.DMEM_WE), 32'(mw));
        check_val("wait_vld", 32'(OUT_VALID), 32'd0);
        check_val("wait_etmo", 32'(ERR_TIMEOUT), 32'd0);
      end
    end
  endtask

  initial begin
    RST_N = 1'b0;
    IN_VALID = 0; IN_RD = 0; IN_Branch = 0; IN_ZERO = 0; IN_MemRead = 0; IN_MemWrite = 0;
    IN_RegWrite = 0; IN_MemToReg = 0; IN_PC = 0; IN_EXE_RESULT = 0; IN_READ_DATA_2 = 0;
    dmem_bus.DMEM_ACK = 0; dmem_bus.DMEM_RDATA = 0;
    exp_mem_data = 32'd0;
    #3;
    check_all_zero("reset");
    check_val("reset_stall", 32'(STALL), 32'd0);
    @(negedge CLK); @(negedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK); #1;

    // args: v rd br zr mr mw rw m2r pc addr wdata ack_at rdata
    do_instr(1, 6'd5, 0, 0, 0, 0, 1, 0, 32'h0, 32'h1234, 32'h0, 9, 32'h0);           // ALU op
    do_instr(1, 6'd7, 0, 0, 1, 0, 1, 1, 32'h0, 32'h100, 32'h0, 3, 32'hDEADBEEF);     // load, ack on 3rd WAIT
    do_instr(1, 6'd9, 0, 0, 0, 0, 1, 0, 32'h0, 32'h55, 32'h0, 9, 32'h0);             // no bubble after load
    do_instr(1, 6'd3, 0, 0, 0, 1, 0, 0, 32'h0, 32'h200, 32'hA5A5A5A5, 1, 32'h11111111); // store, immediate ack
    do_instr(1, 6'd4, 0, 0, 1, 0, 1, 1, 32'h0, 32'h102, 32'h0, 9, 32'h0);            // misaligned load
    do_instr(1, 6'd6, 0, 0, 1, 0, 1, 1, 32'h0, 32'h300, 32'h0, TMO + 1, 32'h0);      // timeout
    do_instr(1, 6'd6, 0, 0, 1, 0, 1, 1, 32'h0, 32'h304, 32'h0, TMO, 32'h0BADF00D);   // ack on last cycle
    do_instr(1, 6'd8, 0, 0, 1, 1, 1, 0, 32'h0, 32'h308, 32'h77, 2, 32'hCAFE0000);    // read+write is a write
    do_instr(1, 6'd0, 1, 1, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0, 0, 32'h99999999);      // branch, stray ack
    do_instr(0, 6'd2, 1, 1, 1, 0, 1, 0, 32'h80, 32'h404, 32'h0, 9, 32'h0);           // bubble with mem bits

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [2:0]  kind;
      a = $urandom();
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      kind = 3'($urandom_range(0, 7));
      do_instr($urandom_range(0, 7) != 0, 6'($urandom()), 1'($urandom()), 1'($urandom()),
               kind inside {3'd1, 3'd2, 3'd5}, kind inside {3'd3, 3'd4, 3'd5},
               1'($urandom()), 1'($urandom()), $urandom(), a, $urandom(),
               $urandom_range(0, TMO + 1), $urandom());
    end

    // Reset in the middle of an outstanding load
    IN_VALID = 1; IN_MemRead = 1; IN_MemWrite = 0; IN_EXE_RESULT = 32'h500; IN_RD = 6'd12;
    IN_Branch = 0; dmem_bus.DMEM_ACK = 0;
    @(negedge CLK); #1;
    check_val("mid_req_up", 32'(dmem_bus.DMEM_REQ), 32'd1);
    @(negedge CLK); #1;
    RST_N = 1'b0; IN_VALID = 0;
    #1;
    exp_mem_data = 32'd0;
    check_all_zero("midreset");
    check_val("midreset_stall", 32'(STALL), 32'd0);
    #1 RST_N = 1'b1;
    @(negedge CLK); #1;
    do_instr(1, 6'd1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h44, 32'h0, 9, 32'h0);
    check_val("post_reset_stall", 32'(STALL), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
